uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
// - Parametrised UART receiver, successor to the fixed 8N1 receiver. Runtime-free, elaboration-time frame format.
// - Configurable data bits, parity and stop bits. 16x-style oversampling with 3-sample majority vote.
// - Reports parity, framing, overrun and break. Delivers bytes through a one-entry valid/ready holding register.
// - Sits between the pad synchroniser-free serial input and a byte consumer (FIFO, command parser).
// PARAMETERS
// SYS_CLOCK      50000000  system clock frequency, Hz
// UART_BAUDRATE  115200    line rate, baud
// OVERSAMPLE     16        samples per bit; even, >=8
// DATA_BITS      8         data bits per frame, 5..9, LSB first
// PARITY_MODE    0         0 none, 1 odd, 2 even
// STOP_BITS      1         1 or 2
// PORTS
// i_SysClock   in   1          system clock, rising edge
// i_ResetN     in   1          synchronous reset, active-low
// i_RxSerial   in   1          asynchronous serial line, idle high
// o_RxData     out  DATA_BITS  received word, valid while o_RxValid
// o_RxValid    out  1          holding register full
// i_RxReady    in   1          consumer accepts word when o_RxValid & i_RxReady
// o_ParityErr  out  1          parity mismatch on held word, qualified by o_RxValid
// o_FrameErr   out  1          a stop bit sampled 0 on held word, qualified by o_RxValid
// o_Overrun    out  1          1-cycle pulse: completed word dropped, holder full
// o_Break      out  1          1-cycle pulse: break condition detected
// o_RxBusy     out  1          state != IDLE
// BEHAVIOUR
// - Reset: i_ResetN sampled on i_SysClock. All outputs 0. Synchroniser flops 1. State IDLE. Counters 0.
// - Reset mid-frame aborts the frame. Holding register contents are discarded.
// - Tick: DIV = SYS_CLOCK/(UART_BAUDRATE*OVERSAMPLE), integer truncation; elaboration error if DIV<2.
//   Divider counts 0..DIV-1 and emits a 1-cycle tick at DIV-1. It is cleared on entry to START, so each bit is edge-aligned.
// - Input: 2-flop synchroniser. All decisions use the 2nd flop.
// - Sample point: oversample indices OVERSAMPLE/2-1, /2, /2+1. Bit value = majority of the three. Bit ends at index OVERSAMPLE-1.
// - FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
//   IDLE: a synchronised 1->0 transition enters START.
//   START: majority 0 at mid-bit continues. Majority 1 = false start, back to IDLE with no outputs.
//   DATA: shift DATA_BITS bits LSB first. Then PARITY if PARITY_MODE!=0, else STOP.
//   PARITY: parity error when sampled bit != expected. Odd: ^data^1. Even: ^data.
//   STOP: STOP_BITS stop bits. Frame error if any stop bit is 0.
//   Frame completion is decided at the mid-bit majority of the last stop bit. The FSM then returns to IDLE without waiting for the bit end, allowing back-to-back frames.
// - Break: all data bits, the parity bit and the first stop bit all sample 0.
//   Action: o_Break pulses 1 cycle, no word is written, go to BRK_WAIT. Stay there until the line is 1 for one full bit time, then IDLE.
// - Delivery: on completion, word+ParityErr+FrameErr load the holder and o_RxValid rises the next cycle. Latency = 1 clock after the deciding sample.
//   o_RxValid falls the cycle after a handshake, unless a new word loads in the same cycle. In that case the new word replaces it and o_RxValid stays 1.
// - Overrun: completion while o_RxValid=1 and no handshake that cycle. The new word is dropped, the old word is kept, o_Overrun pulses 1 cycle.
// - Word width: o_RxData is exactly DATA_BITS wide. There are no padding bits.
// STRUCTURE
// - Package uart_pkg: PARITY_NONE/ODD/EVEN constants, FSM state encoding, function uart_div(sys,baud,os).
// - Sub-module uart_baud_tick (divider + tick, shared with the TX side). Instantiated once.
// - Remainder is local: synchroniser, FSM, oversample index, bit counter, shift register, holding register.
// TESTING (SYS_CLOCK 50e6, baud 115200, OVERSAMPLE 16 -> DIV 27)
// 1 8N1, i_RxReady=1, send 0xA5 then 0x3C back-to-back
//   -> two o_RxValid cycles, data 0xA5, 0x3C, all errors 0.
// 2 8E1, send data 0x03 with parity bit 1
//   -> o_RxData=0x03, o_ParityErr=1. Then send 0x03 with parity 0 -> o_ParityErr=0.
// 3 8N2, send 0x55 with second stop bit 0
//   -> o_FrameErr=1 with 0x55. A low pulse of 4 oversample ticks on an idle line -> no o_RxValid, o_RxBusy returns to 0.
// 4 i_RxReady=0, send 0x11 then 0x22
//   -> o_RxData stays 0x11, one o_Overrun pulse. Assert i_RxReady -> 0x11 consumed, o_RxValid=0, no 0x22.
// 5 Line low 20 bit times, then high, then send 0x7E
//   -> exactly one o_Break pulse, no o_RxValid during the break, then 0x7E received cleanly.
// 6 Pull i_ResetN low for 1 clock during data bit 3 of 0xC3
//   -> all outputs 0 the next cycle, no word delivered. The next frame 0x96 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding, baud divider helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    function automatic int uart_div(input int sys_clk, input int baud, input int os);
        return sys_clk / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses at DIV-1; i_Clear restarts the count.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic i_SysClock,
    input  logic i_ResetN,
    input  logic i_Clear,
    output logic o_Tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_Clear || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_SysClock) begin
        if (!i_ResetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled majority-vote bit recovery, parity/frame/break/overrun
// reporting, and a one-entry valid/ready holding register.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = PARITY_NONE,
    parameter int STOP_BITS     = 1
) (
    input  logic                 i_SysClock,
    input  logic                 i_ResetN,
    input  logic                 i_RxSerial,
    output logic [DATA_BITS-1:0] o_RxData,
    output logic                 o_RxValid,
    input  logic                 i_RxReady,
    output logic                 o_ParityErr,
    output logic                 o_FrameErr,
    output logic                 o_Overrun,
    output logic                 o_Break,
    output logic                 o_RxBusy
);

    localparam int DIV  = uart_div(SYS_CLOCK, UART_BAUDRATE, OVERSAMPLE);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] IDX_S0   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] IDX_S1   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] IDX_S2   = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0] IDX_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx_cfg: baud divider must be at least 2");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_EVEN ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_fmt
        $error("uart_rx_cfg: unsupported frame format");
    end

    rx_state_e            state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [1:0]           flush_q;
    logic [OS_W-1:0]      os_idx_q, os_idx_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic                 zero_q, zero_d, perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic                 hold_perr_q, hold_perr_d, hold_ferr_q, hold_ferr_d;
    logic                 valid_q, valid_d, overrun_q, overrun_d, break_q, break_d;
    logic                 tick, div_clear, complete, handshake;
    logic                 rx, maj, fall, mid, bit_end, exp_par, ferr_new;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .i_SysClock (i_SysClock),
        .i_ResetN   (i_ResetN),
        .i_Clear    (div_clear),
        .o_Tick     (tick)
    );

    assign rx        = sync2_q;
    assign fall      = prev_q & ~rx;
    assign maj       = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
    assign mid       = tick && (os_idx_q == IDX_S2);
    assign bit_end   = tick && (os_idx_q == IDX_LAST);
    assign exp_par   = (PARITY_MODE == PARITY_ODD) ? ~(^shreg_q) : ^shreg_q;
    assign ferr_new  = ferr_acc_q | ~maj;
    assign handshake = valid_q & i_RxReady;

    always_comb begin
        state_d     = state_q;
        os_idx_d    = os_idx_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        zero_d      = zero_q;
        perr_acc_d  = perr_acc_q;
        ferr_acc_d  = ferr_acc_q;
        hold_data_d = hold_data_q;
        hold_perr_d = hold_perr_q;
        hold_ferr_d = hold_ferr_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        break_d     = 1'b0;
        div_clear   = 1'b0;
        complete    = 1'b0;

        if (tick && state_q != ST_IDLE && state_q != ST_BRK_WAIT) begin
            os_idx_d = (os_idx_q == IDX_LAST) ? '0 : os_idx_q + 1'b1;
            if (os_idx_q == IDX_S0) s0_d = rx;
            if (os_idx_q == IDX_S1) s1_d = rx;
        end

        case (state_q)
            ST_IDLE: if (fall) begin
                state_d   = ST_START;
                os_idx_d  = '0;
                div_clear = 1'b1;
            end
            ST_START: begin
                if (mid && maj) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d    = ST_DATA;
                    bit_cnt_d  = '0;
                    zero_d     = 1'b1;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (mid) begin
                    shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                    zero_d  = zero_q & ~maj;
                end else if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_PARITY: begin
                if (mid) begin
                    perr_acc_d = (maj != exp_par);
                    zero_d     = zero_q & ~maj;
                end else if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (mid) begin
                    if (bit_cnt_q == 4'd0 && zero_q && !maj) begin
                        break_d  = 1'b1;
                        state_d  = ST_BRK_WAIT;
                        os_idx_d = '0;
                    end else if (bit_cnt_q == STOP_LAST) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        ferr_acc_d = ferr_new;
                    end
                end else if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            // Line must stay high for a whole bit time before a new start edge is honoured.
            ST_BRK_WAIT: if (tick) begin
                if (!rx) begin
                    os_idx_d = '0;
                end else if (os_idx_q == IDX_LAST) begin
                    state_d  = ST_IDLE;
                    os_idx_d = '0;
                end else begin
                    os_idx_d = os_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            if (!valid_q || handshake) begin
                hold_data_d = shreg_q;
                hold_perr_d = perr_acc_q;
                hold_ferr_d = ferr_new;
                valid_d     = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_SysClock) begin
        if (!i_ResetN) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b0;
            flush_q     <= '0;
            os_idx_q    <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            zero_q      <= 1'b0;
            perr_acc_q  <= 1'b0;
            ferr_acc_q  <= 1'b0;
            hold_data_q <= '0;
            hold_perr_q <= 1'b0;
            hold_ferr_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= i_RxSerial;
            sync2_q     <= sync1_q;
            // Edge history only tracks the line once the synchroniser holds real samples,
            // so a line that is low when reset releases is not mistaken for a start edge.
            prev_q      <= flush_q[1] ? sync2_q : 1'b0;
            flush_q     <= {flush_q[0], 1'b1};
            os_idx_q    <= os_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            zero_q      <= zero_d;
            perr_acc_q  <= perr_acc_d;
            ferr_acc_q  <= ferr_acc_d;
            hold_data_q <= hold_data_d;
            hold_perr_q <= hold_perr_d;
            hold_ferr_q <= hold_ferr_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            break_q     <= break_d;
        end
    end

    assign o_RxData    = hold_data_q;
    assign o_RxValid   = valid_q;
    assign o_ParityErr = hold_perr_q;
    assign o_FrameErr  = hold_ferr_q;
    assign o_Overrun   = overrun_q;
    assign o_Break     = break_q;
    assign o_RxBusy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 8N2 instances driven with hand-built frames.
module tb_uart_rx_cfg;

    localparam int BIT_CLKS = 432;  // 16 oversamples x divider 27

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_n, rx_a, rx_b, rx_c, ready_a;
    logic [7:0] a_data, b_data, c_data;
    logic       a_valid, a_perr, a_ferr, a_ovr, a_brk, a_busy;
    logic       b_valid, b_perr, b_ferr, b_ovr, b_brk, b_busy;
    logic       c_valid, c_perr, c_ferr, c_ovr, c_brk, c_busy;

    int checks = 0;
    int errors = 0;
    int vcnt_a = 0, ovr_a = 0, brk_a = 0;
    logic [31:0] q_a[$], q_b[$], q_c[$];
    logic [31:0] got;

    uart_rx_cfg #(.PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_RxSerial(rx_a), .o_RxData(a_data),
        .o_RxValid(a_valid), .i_RxReady(ready_a), .o_ParityErr(a_perr), .o_FrameErr(a_ferr),
        .o_Overrun(a_ovr), .o_Break(a_brk), .o_RxBusy(a_busy));

    uart_rx_cfg #(.PARITY_MODE(2), .STOP_BITS(1)) dut_b (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_RxSerial(rx_b), .o_RxData(b_data),
        .o_RxValid(b_valid), .i_RxReady(1'b1), .o_ParityErr(b_perr), .o_FrameErr(b_ferr),
        .o_Overrun(b_ovr), .o_Break(b_brk), .o_RxBusy(b_busy));

    uart_rx_cfg #(.PARITY_MODE(0), .STOP_BITS(2)) dut_c (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_RxSerial(rx_c), .o_RxData(c_data),
        .o_RxValid(c_valid), .i_RxReady(1'b1), .o_ParityErr(c_perr), .o_FrameErr(c_ferr),
        .o_Overrun(c_ovr), .o_Break(c_brk), .o_RxBusy(c_busy));

    // Accepted words are logged as {perr, ferr, data}.
    always @(negedge clk) begin
        if (a_valid) vcnt_a++;
        if (a_valid && ready_a) q_a.push_back({22'd0, a_perr, a_ferr, a_data});
        if (a_ovr) ovr_a++;
        if (a_brk) brk_a++;
        if (b_valid) q_b.push_back({22'd0, b_perr, b_ferr, b_data});
        if (c_valid) q_c.push_back({22'd0, c_perr, c_ferr, c_data});
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input int clks);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
        wait_clks(clks);
    endtask

    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) drive(sel, bits[i], BIT_CLKS);
    endtask

    function automatic logic [15:0] frame_n1(input logic [7:0] w);
        return {6'd0, 1'b1, w, 1'b0};
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1; ready_a = 1'b1;
        wait_clks(5);
        check("rst_a_flags", {26'd0, a_valid, a_perr, a_ferr, a_ovr, a_brk, a_busy}, 32'd0);
        check("rst_a_data", {24'd0, a_data}, 32'd0);
        check("rst_bc_flags", {28'd0, b_valid, b_busy, c_valid, c_busy}, 32'd0);
        rst_n = 1'b1;
        wait_clks(5);

        // 1: 8N1 back-to-back frames
        send_bits(0, frame_n1(8'hA5), 10);
        send_bits(0, frame_n1(8'h3C), 10);
        wait_clks(BIT_CLKS);
        check("t1_valid_cycles", vcnt_a, 2);
        check("t1_words", q_a.size(), 2);
        got = (q_a.size() > 0) ? q_a.pop_front() : 32'hDEAD; check("t1_word0", got, 32'h0A5);
        got = (q_a.size() > 0) ? q_a.pop_front() : 32'hDEAD; check("t1_word1", got, 32'h03C);
        check("t1_idle", {31'd0, a_busy}, 32'd0);

        // 2: 8E1, 0x03 has even weight so the expected parity bit is 0
        send_bits(1, {4'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        wait_clks(BIT_CLKS);
        got = (q_b.size() > 0) ? q_b.pop_front() : 32'hDEAD; check("t2_bad_parity", got, 32'h203);
        send_bits(1, {4'd0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        wait_clks(BIT_CLKS);
        got = (q_b.size() > 0) ? q_b.pop_front() : 32'hDEAD; check("t2_good_parity", got, 32'h003);

        // 3: 8N2 with second stop bit low, then a 4-tick glitch
        send_bits(2, {4'd0, 1'b0, 1'b1, 8'h55, 1'b0}, 11);
        drive(2, 1'b1, BIT_CLKS);
        got = (q_c.size() > 0) ? q_c.pop_front() : 32'hDEAD; check("t3_frame_err", got, 32'h155);
        drive(2, 1'b0, 50);
        check("t3_glitch_busy", {31'd0, c_busy}, 32'd1);
        drive(2, 1'b0, 58);
        drive(2, 1'b1, 2 * BIT_CLKS);
        check("t3_glitch_no_word", q_c.size(), 0);
        check("t3_glitch_idle", {31'd0, c_busy}, 32'd0);

        // 4: overrun with consumer stalled
        ready_a = 1'b0;
        ovr_a = 0;
        send_bits(0, frame_n1(8'h11), 10);
        send_bits(0, frame_n1(8'h22), 10);
        wait_clks(BIT_CLKS);
        check("t4_held_valid", {31'd0, a_valid}, 32'd1);
        check("t4_held_data", {24'd0, a_data}, 32'h11);
        check("t4_overrun_pulses", ovr_a, 1);
        ready_a = 1'b1;
        wait_clks(3);
        check("t4_drained", {31'd0, a_valid}, 32'd0);
        got = (q_a.size() > 0) ? q_a.pop_front() : 32'hDEAD; check("t4_consumed", got, 32'h011);
        wait_clks(BIT_CLKS);
        check("t4_no_second", q_a.size(), 0);

        // 5: break, recovery, clean frame
        brk_a = 0;
        vcnt_a = 0;
        drive(0, 1'b0, 15 * BIT_CLKS);
        check("t5_brk_busy", {31'd0, a_busy}, 32'd1);
        drive(0, 1'b0, 5 * BIT_CLKS);
        drive(0, 1'b1, 2 * BIT_CLKS);
        check("t5_brk_pulses", brk_a, 1);
        check("t5_no_valid", vcnt_a, 0);
        check("t5_recovered", {31'd0, a_busy}, 32'd0);
        send_bits(0, frame_n1(8'h7E), 10);
        wait_clks(BIT_CLKS);
        got = (q_a.size() > 0) ? q_a.pop_front() : 32'hDEAD; check("t5_after_brk", got, 32'h07E);

        // 6: reset pulse during data bit 3 of 0xC3 (bits LSB first: 1,1,0,0,0,0,1,1)
        send_bits(0, 16'b0110, 4);
        drive(0, 1'b0, 200);
        check("t6_pre_busy", {31'd0, a_busy}, 32'd1);
        rst_n = 1'b0;
        wait_clks(1);
        check("t6_rst_flags", {26'd0, a_valid, a_perr, a_ferr, a_ovr, a_brk, a_busy}, 32'd0);
        check("t6_rst_data", {24'd0, a_data}, 32'd0);
        rst_n = 1'b1;
        drive(0, 1'b0, BIT_CLKS - 201);
        send_bits(0, 16'b11100, 5);
        drive(0, 1'b1, BIT_CLKS);
        check("t6_no_word", q_a.size(), 0);
        send_bits(0, frame_n1(8'h96), 10);
        wait_clks(BIT_CLKS);
        got = (q_a.size() > 0) ? q_a.pop_front() : 32'hDEAD; check("t6_next_frame", got, 32'h096);
        check("t6_only_one", q_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
